// File: rtl/seq_counter_ctrl.sv
// seq_counter_ctrl
//   Sequence-counter and run-control stage for the multicycle processor.
//   Produces the registered 4-bit timing-state count for the downstream
//   4-to-16 timing decoder. It also holds the run flag, the interrupt-cycle
//   flag and a counter of completed instructions.
//
// Ports
//   clk     : system clock, all state updates on the rising edge
//   rst     : asynchronous, active-high reset
//   start   : set run flag
//   halt    : clear run flag and force sc to 0 (wins over start)
//   sc_clr  : end of instruction/interrupt cycle, sc returns to 0
//   sc_hold : stall, sc keeps its value
//   irq     : interrupt request (level), sampled only on sc_clr
//   ien     : interrupt enable, sampled only on sc_clr
//   sc      : timing-state count, sc[3] is the MSB
//   run     : processor running
//   r_flag  : next/current cycle is an interrupt cycle
//   ov      : one-cycle pulse after sc wraps 15->0 without sc_clr
//   icnt    : completed instructions since reset (wraps)
module seq_counter_ctrl #(
   parameter int unsigned ICNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              halt,
   input  logic              sc_clr,
   input  logic              sc_hold,
   input  logic              irq,
   input  logic              ien,
   output logic [3:0]        sc,
   output logic              run,
   output logic              r_flag,
   output logic              ov,
   output logic [ICNT_W-1:0] icnt
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        sc_q, sc_d;
   logic              r_flag_q, r_flag_d;
   logic              ov_q, ov_d;
   logic [ICNT_W-1:0] icnt_q, icnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         sc_q     <= '0;
         r_flag_q <= 1'b0;
         ov_q     <= 1'b0;
         icnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         sc_q     <= sc_d;
         r_flag_q <= r_flag_d;
         ov_q     <= ov_d;
         icnt_q   <= icnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      sc_d     = sc_q;
      r_flag_d = r_flag_q;
      ov_d     = 1'b0;
      icnt_d   = icnt_q;
      case (state_q)
         ST_IDLE: begin
            sc_d = '0;
            if (start && !halt) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (halt) begin
               state_d = ST_IDLE;
               sc_d    = '0;
            end else if (sc_clr) begin
               sc_d     = '0;
               icnt_d   = icnt_q + ICNT_W'(1);
               // An interrupt cycle lasts exactly one instruction length:
               // a set flag always clears at the next sc_clr.
               r_flag_d = r_flag_q ? 1'b0 : (irq & ien);
            end else if (!sc_hold) begin
               sc_d = sc_q + 4'd1;
               ov_d = (sc_q == 4'hF);
            end
         end
         default: begin
            state_d = ST_IDLE;
            sc_d    = '0;
         end
      endcase
   end

   assign sc     = sc_q;
   assign run    = (state_q == ST_RUN);
   assign r_flag = r_flag_q;
   assign ov     = ov_q;
   assign icnt   = icnt_q;

endmodule

// File: tb/tb_seq_counter_ctrl.sv
// Directed testbench for seq_counter_ctrl. Inputs change 1 ns after each
// rising edge; outputs are sampled at that same point.
module tb_seq_counter_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, halt = 1'b0, sc_clr = 1'b0, sc_hold = 1'b0;
   logic       irq = 1'b0, ien = 1'b0;
   logic [3:0] sc;
   logic       run, r_flag, ov;
   logic [7:0] icnt;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   seq_counter_ctrl #(.ICNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .halt(halt), .sc_clr(sc_clr),
      .sc_hold(sc_hold), .irq(irq), .ien(ien), .sc(sc), .run(run),
      .r_flag(r_flag), .ov(ov), .icnt(icnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset, then one start cycle: afterwards run=1, sc=0, icnt=0.
   task automatic reset_start();
      start = 0; halt = 0; sc_clr = 0; sc_hold = 0; irq = 0; ien = 0;
      rst = 1; #3; rst = 0;
      step();
      start = 1;
      step();
      start = 0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (sc !== 4'd0) begin n_fail++; $display("FAIL reset_sc got=%0d exp=0", sc); end
      n_checks++; if (run !== 1'b0) begin n_fail++; $display("FAIL reset_run got=%b exp=0", run); end
      n_checks++; if (r_flag !== 1'b0) begin n_fail++; $display("FAIL reset_rflag got=%b exp=0", r_flag); end
      n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL reset_ov got=%b exp=0", ov); end
      n_checks++; if (icnt !== 8'd0) begin n_fail++; $display("FAIL reset_icnt got=%0d exp=0", icnt); end
      rst = 0;
      // idle: sc stays 0 even with sc_clr
      sc_clr = 1; step(); step(); sc_clr = 0;
      n_checks++; if (sc !== 4'd0 || run !== 1'b0 || icnt !== 8'd0) begin n_fail++; $display("FAIL idle_hold sc=%0d run=%b icnt=%0d exp 0/0/0", sc, run, icnt); end
   endtask

   task automatic test_free_run();
      reset_start();
      n_checks++; if (run !== 1'b1 || sc !== 4'd0) begin n_fail++; $display("FAIL start run=%b sc=%0d exp 1/0", run, sc); end
      for (int i = 1; i <= 15; i++) begin
         step();
         n_checks++; if (sc !== 4'(i) || ov !== 1'b0) begin n_fail++; $display("FAIL free_sc%0d sc=%0d ov=%b exp %0d/0", i, sc, ov, i); end
      end
      step();
      n_checks++; if (sc !== 4'd0 || ov !== 1'b1) begin n_fail++; $display("FAIL wrap sc=%0d ov=%b exp 0/1", sc, ov); end
      step();
      n_checks++; if (sc !== 4'd1 || ov !== 1'b0) begin n_fail++; $display("FAIL after_wrap sc=%0d ov=%b exp 1/0", sc, ov); end
      n_checks++; if (icnt !== 8'd0 || run !== 1'b1) begin n_fail++; $display("FAIL free_icnt icnt=%0d run=%b exp 0/1", icnt, run); end
   endtask

   task automatic test_sc_clr();
      reset_start();
      for (int r = 0; r < 3; r++) begin
         for (int i = 1; i <= 3; i++) begin
            step();
            n_checks++; if (sc !== 4'(i) || ov !== 1'b0) begin n_fail++; $display("FAIL clr_seq r%0d sc=%0d ov=%b exp %0d/0", r, sc, ov, i); end
         end
         sc_clr = 1; step(); sc_clr = 0;
         n_checks++; if (sc !== 4'd0 || ov !== 1'b0) begin n_fail++; $display("FAIL clr_zero r%0d sc=%0d ov=%b exp 0/0", r, sc, ov); end
      end
      n_checks++; if (icnt !== 8'd3) begin n_fail++; $display("FAIL clr_icnt got=%0d exp=3", icnt); end
   endtask

   task automatic test_hold();
      reset_start();
      step(); step();
      n_checks++; if (sc !== 4'd2) begin n_fail++; $display("FAIL hold_pre got=%0d exp=2", sc); end
      sc_hold = 1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++; if (sc !== 4'd2) begin n_fail++; $display("FAIL hold_%0d got=%0d exp=2", i, sc); end
      end
      sc_hold = 0;
      step();
      n_checks++; if (sc !== 4'd3) begin n_fail++; $display("FAIL hold_release got=%0d exp=3", sc); end
      step(); step();
      n_checks++; if (sc !== 4'd5) begin n_fail++; $display("FAIL hold_at5 got=%0d exp=5", sc); end
      sc_hold = 1; sc_clr = 1; step(); sc_hold = 0; sc_clr = 0;
      n_checks++; if (sc !== 4'd0 || icnt !== 8'd1) begin n_fail++; $display("FAIL hold_clr sc=%0d icnt=%0d exp 0/1", sc, icnt); end
   endtask

   task automatic test_irq();
      reset_start();
      // irq without sc_clr is not recorded
      ien = 1; irq = 1; step();
      n_checks++; if (r_flag !== 1'b0) begin n_fail++; $display("FAIL irq_noclr got=%b exp=0", r_flag); end
      sc_clr = 1; step(); sc_clr = 0;
      n_checks++; if (r_flag !== 1'b1 || sc !== 4'd0) begin n_fail++; $display("FAIL irq_set rflag=%b sc=%0d exp 1/0", r_flag, sc); end
      step(); step();
      n_checks++; if (r_flag !== 1'b1) begin n_fail++; $display("FAIL irq_keep got=%b exp=1", r_flag); end
      sc_clr = 1; step(); sc_clr = 0;
      n_checks++; if (r_flag !== 1'b0) begin n_fail++; $display("FAIL irq_clear got=%b exp=0", r_flag); end
      ien = 0; sc_clr = 1; step(); sc_clr = 0; irq = 0;
      n_checks++; if (r_flag !== 1'b0 || icnt !== 8'd3) begin n_fail++; $display("FAIL irq_masked rflag=%b icnt=%0d exp 0/3", r_flag, icnt); end
   endtask

   task automatic test_halt();
      reset_start();
      sc_clr = 1; step(); sc_clr = 0;
      for (int i = 0; i < 6; i++) step();
      n_checks++; if (sc !== 4'd6 || icnt !== 8'd1) begin n_fail++; $display("FAIL halt_pre sc=%0d icnt=%0d exp 6/1", sc, icnt); end
      halt = 1; sc_clr = 1; step(); halt = 0;
      n_checks++; if (run !== 1'b0 || sc !== 4'd0 || icnt !== 8'd1) begin n_fail++; $display("FAIL halt_clr run=%b sc=%0d icnt=%0d exp 0/0/1", run, sc, icnt); end
      step(); sc_clr = 0;
      n_checks++; if (sc !== 4'd0 || icnt !== 8'd1) begin n_fail++; $display("FAIL halted_idle sc=%0d icnt=%0d exp 0/1", sc, icnt); end
      start = 1; halt = 1; step(); halt = 0;
      n_checks++; if (run !== 1'b0) begin n_fail++; $display("FAIL start_halt run=%b exp=0", run); end
      step(); start = 0;
      n_checks++; if (run !== 1'b1 || sc !== 4'd0) begin n_fail++; $display("FAIL restart run=%b sc=%0d exp 1/0", run, sc); end
      step();
      n_checks++; if (sc !== 4'd1) begin n_fail++; $display("FAIL restart_sc got=%0d exp=1", sc); end
   endtask

   task automatic test_icnt_wrap_and_rst();
      reset_start();
      sc_clr = 1;
      for (int i = 0; i < 255; i++) step();
      n_checks++; if (icnt !== 8'd255) begin n_fail++; $display("FAIL icnt_255 got=%0d exp=255", icnt); end
      step();
      n_checks++; if (icnt !== 8'd0) begin n_fail++; $display("FAIL icnt_wrap got=%0d exp=0", icnt); end
      ien = 1; irq = 1; step(); sc_clr = 0; ien = 0; irq = 0;
      n_checks++; if (icnt !== 8'd1 || r_flag !== 1'b1) begin n_fail++; $display("FAIL icnt_one icnt=%0d rflag=%b exp 1/1", icnt, r_flag); end
      for (int i = 0; i < 9; i++) step();
      n_checks++; if (sc !== 4'd9) begin n_fail++; $display("FAIL pre_rst sc=%0d exp=9", sc); end
      // asynchronous reset, checked well before the next edge
      rst = 1; #1;
      n_checks++; if (sc !== 4'd0 || run !== 1'b0 || r_flag !== 1'b0 || ov !== 1'b0 || icnt !== 8'd0) begin
         n_fail++; $display("FAIL async_rst sc=%0d run=%b rflag=%b ov=%b icnt=%0d exp all 0", sc, run, r_flag, ov, icnt);
      end
      #1; rst = 0;
      step(); step(); step();
      n_checks++; if (sc !== 4'd0 || run !== 1'b0) begin n_fail++; $display("FAIL post_rst sc=%0d run=%b exp 0/0", sc, run); end
      start = 1; step(); start = 0; step();
      n_checks++; if (run !== 1'b1 || sc !== 4'd1) begin n_fail++; $display("FAIL post_rst_start run=%b sc=%0d exp 1/1", run, sc); end
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_sc_clr();
      test_hold();
      test_irq();
      test_halt();
      test_icnt_wrap_and_rst();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_counter_ctrl.md
# seq_counter_ctrl

Sequence-counter and run-control stage for the multicycle processor. Produces the registered 4-bit timing-state count that feeds the 4-to-16 timing decoder directly downstream (sc[3] drives the decoder's MSB select, sc[0] its LSB), so exactly one T-line T0..T15 is active per cycle. Also owns the run flag, the interrupt-cycle flag and a completed-instruction counter used by the control unit.

## Interface
Parameters:
- ICNT_W, 8, width of completed-instruction counter

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  set run flag (begin executing)
- halt  input  1  clear run flag (HLT instruction), forces SC to 0
- sc_clr  input  1  end of current instruction/interrupt cycle; SC returns to 0
- sc_hold  input  1  stall (memory wait); SC holds value
- irq  input  1  interrupt request, level
- ien  input  1  interrupt enable flag from control unit
- sc  output  4  timing-state count, sc[3]=MSB
- run  output  1  processor running
- r_flag  output  1  next/current cycle is an interrupt cycle
- ov  output  1  one-cycle pulse: SC wrapped 15->0 without sc_clr
- icnt  output  ICNT_W  completed instructions since reset

## Operation
- Reset (async, immediate on rst rising, held while rst=1): sc=0, run=0, r_flag=0, ov=0, icnt=0.
- run=0: sc held at 0 regardless of sc_clr/sc_hold; icnt, r_flag frozen; ov=0. start=1 -> run=1 next edge. start and halt both 1 -> halt wins, run stays 0.
- run=1, per edge, priority order:
  - halt=1: run<=0, sc<=0; icnt, r_flag unchanged; start ignored.
  - sc_clr=1: sc<=0; icnt<=icnt+1 (modulo 2^ICNT_W, wraps to 0); r_flag<= r_flag ? 0 : (irq & ien). sc_hold ignored.
  - sc_hold=1: sc unchanged.
  - else: sc<=sc+1; at sc=15, sc<=0 and ov<=1 for the next cycle only; run unaffected.
- ov is registered; it is 0 on every cycle not immediately following an unclear wrap.
- All outputs are registers; no combinational path from any input to any output.

## Timing
- Latency: every input affects outputs at the next rising clk edge (one cycle); reset is asynchronous.
- After start at edge N: run=1 after N, sc=0 during cycle N+1, sc=1 after edge N+1.
- sc_clr sampled with sc=k: sc=0 the following cycle; the T-line sequence restarts at T0.
- irq/ien sampled only on the sc_clr edge; an irq pulse not overlapping an sc_clr edge is not recorded.
- r_flag, once set, stays set through exactly one instruction-length cycle and clears at the next sc_clr.
- rst asserted mid-instruction: all outputs zero immediately; after release, sc stays 0 until start.

## Test plan
- Reset then start=1 one cycle, no other inputs -> run=1, sc steps 0,1,2,...,15,0; ov=1 exactly in the cycle sc first returns to 0; icnt=0.
- Run, sc_clr pulsed when sc=3, three times -> sc sequence 0..3,0..3,0..3,0; icnt=3; ov never 1.
- Run, sc_hold=1 for 4 cycles at sc=2 -> sc=2 for 5 cycles total then 3; sc_hold and sc_clr together at sc=5 -> sc=0, icnt increments.
- Run, ien=1, irq=1 at sc_clr -> r_flag=1 next cycle; next sc_clr with irq still 1 -> r_flag=0; ien=0, irq=1 at sc_clr -> r_flag stays 0.
- Run, halt=1 and sc_clr=1 same edge at sc=6 -> run=0, sc=0, icnt unchanged; start=1 and halt=1 same edge -> run stays 0.
- ICNT_W=8, 256 sc_clr events -> icnt wraps 255->0; rst pulse mid-count at sc=9 -> sc, run, r_flag, ov, icnt all 0 immediately, sc holds 0 until start.
